// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks register writes that are in flight between ID issue
// and write-back, and raises the ID-stage stall. With forwarding enabled,
// only load-use hazards stall; without forwarding, any pending write to a
// source stalls. A per-register counter at its maximum also stalls a new
// writer to that register.
module reg_scoreboard #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            forward,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_src1,
  input  logic [AW-1:0]   id_src2,
  input  logic            id_two_src,
  input  logic            id_wb_en,
  input  logic [AW-1:0]   id_dest,
  input  logic            id_mem_read,
  input  logic            wb_wb_en,
  input  logic [AW-1:0]   wb_dest,
  output logic            stall,
  output logic            issue,
  output logic [NREG-1:0] busy,
  output logic            underflow
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  // Gathered copy of every per-register counter, read by the hazard logic.
  logic [NREG-1:0][CW-1:0] cnt_all;
  // Per-register flag: a retire hit a register whose count is already zero.
  logic [NREG-1:0]         uf_hit;

  logic          ex_load_vld_reg;
  logic [AW-1:0] ex_load_dest_reg;
  logic          underflow_reg;

  logic h1_pend, h2_pend, h1_load, h2_load, sat_hit, hazard;

  // Hazard detection uses registered counters only, so a retire in the
  // same cycle as the read does not unblock that cycle.
  always_comb begin
    h1_pend = 1'b0;
    h2_pend = 1'b0;
    h1_load = 1'b0;
    h2_load = 1'b0;
    sat_hit = 1'b0;
    hazard  = 1'b0;

    h1_pend = (cnt_all[id_src1] != '0);
    h2_pend = id_two_src & (cnt_all[id_src2] != '0);
    h1_load = ex_load_vld_reg & (ex_load_dest_reg == id_src1);
    h2_load = id_two_src & ex_load_vld_reg & (ex_load_dest_reg == id_src2);
    sat_hit = id_wb_en & (cnt_all[id_dest] == CNT_MAX);

    if (forward) begin
      hazard = h1_load | h2_load;
    end else begin
      hazard = h1_pend | h2_pend;
    end
  end

  assign stall     = id_valid & (hazard | sat_hit);
  assign issue     = id_valid & ~stall;
  assign underflow = underflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_cnt
      logic [CW-1:0] cnt_reg;
      logic          inc;
      logic          dec;

      assign inc         = issue & id_wb_en & (id_dest == AW'(gi));
      assign dec         = wb_wb_en & (wb_dest == AW'(gi));
      assign uf_hit[gi]  = dec & ~inc & (cnt_reg == '0);
      assign busy[gi]    = (cnt_reg != '0);
      assign cnt_all[gi] = cnt_reg;

      // In-flight count for this register: +1 on issue, -1 on retire,
      // hold when both happen together or when a retire finds it empty.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (inc & ~dec) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (dec & ~inc & (cnt_reg != '0)) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end
  endgenerate

  // Track the load issued last cycle (now in EXE); clears itself unless
  // another load issues on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_load_vld_reg  <= 1'b0;
      ex_load_dest_reg <= '0;
    end else begin
      ex_load_vld_reg  <= issue & id_mem_read & id_wb_en;
      if (issue & id_mem_read & id_wb_en) begin
        ex_load_dest_reg <= id_dest;
      end
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_reg <= 1'b0;
    end else if (|uf_hit) begin
      underflow_reg <= 1'b1;
    end
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register scoreboard for the 5-stage pipeline: tracks which architectural registers have a write in flight between ID issue and write-back, and raises the ID-stage stall. It is the producer side of the hazard information the forwarding path consumes. It sits beside the ID stage:
- ID presents decoded sources and destination.
- WB reports retiring writes.
- The block gates issue so a consumer never reads a stale value.
- With forwarding enabled, it stalls only on load-use; with forwarding disabled, it stalls on any pending write to a source.

## Interface
- NREG, 16, number of architectural registers
- AW, 4, register index width (NREG = 2**AW)
- CW, 2, per-register in-flight counter width; max count 2**CW-1

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- forward  in  1  1 = forwarding enabled (load-use stalls only); 0 = stall on any pending source
- id_valid  in  1  ID holds a valid instruction
- id_src1  in  AW  first source register
- id_src2  in  AW  second source register
- id_two_src  in  1  id_src2 is actually read
- id_wb_en  in  1  instruction writes id_dest
- id_dest  in  AW  destination register
- id_mem_read  in  1  instruction is a load
- wb_wb_en  in  1  WB stage retires a register write this cycle
- wb_dest  in  AW  register retired
- stall  out  1  hold IF/ID this cycle; combinational from state and ID inputs
- issue  out  1  id_valid & ~stall
- busy  out  NREG  bit r = counter[r] != 0
- underflow  out  1  sticky: a retire hit a register with count 0

## Operation
- State:
  - cnt[r] (CW bits) per register.
  - ex_load_vld (1 bit), ex_load_dest (AW bits): the load issued last cycle, now in EXE.
  - underflow (sticky).
- Source hit: h1 = src1 matches; h2 = id_two_src & src2 matches.
- Pending-write stall (forward=0): h1 or h2 against cnt != 0.
- Load-use stall (forward=1): h1 or h2 against ex_load_vld & ex_load_dest.
- Saturation stall (both modes): id_wb_en & cnt[id_dest] == max.
- stall = id_valid & (selected hazard | saturation). stall is 0 whenever id_valid=0.
- Counter update per edge, for each register r:
  - inc = issue & id_wb_en & id_dest==r.
  - dec = wb_wb_en & wb_dest==r.
  - inc&dec: hold. inc only: +1. dec only with cnt>0: -1.
  - dec only with cnt==0: hold at 0 and set underflow.
- Load tracker: ex_load_vld <= issue & id_mem_read & id_wb_en; ex_load_dest <= id_dest on that edge. The tracker self-clears the cycle after unless another load issues.
- A retire in the same cycle as an ID read of that register does not unblock that cycle; the stall is computed from registered cnt (WB-to-ID bypass is the register file's job).
- Counters ignore the forward input; only stall selection changes with mode. Toggling forward mid-run is legal and takes effect combinationally.

## Timing
- Reset (rst=1 at edge): all cnt=0, ex_load_vld=0, ex_load_dest=0, underflow=0. Consequently busy=0, stall=0, and issue=id_valid.
- Issue-to-busy latency: 1 cycle (busy[d] rises on the edge that accepts the instruction).
- Retire-to-clear latency: 1 cycle.
- Load-use stall: exactly 1 cycle for a dependent instruction immediately following a load (forward=1).
- Back-to-back writes to one register: count reaches 2, then 3; the 4th issue stalls until a retire (CW=2).
- rst asserted mid-operation overrides all increments, decrements, and the tracker on that edge. In-flight instructions are the pipeline's responsibility to flush alongside.

## Test plan
- Reset: hold rst 2 cycles with id_valid=1, src1=3, then release -> busy=0x0000, stall=0, issue=1, underflow=0.
- forward=0 RAW:
  - Issue wb to R5; next cycle ID src1=5 -> stall=1 every cycle while busy[5]=1.
  - Pulse wb_wb_en, wb_dest=5 -> busy[5]=0 after the edge, stall=0 the following cycle.
- forward=1 load-use:
  - Issue load to R2, then ID src2=2 with id_two_src=1 -> stall=1 for exactly 1 cycle, then issue=1.
  - Same sequence with id_two_src=0 -> stall=0.
- Saturation: issue 3 writes to R7 without retires -> cnt=3; 4th write to R7 -> stall=1 (forward=1 and 0); one retire of R7 -> issue resumes next cycle.
- Simultaneous inc/dec on R9 with cnt=1 -> cnt stays 1, busy[9]=1.
- Retire R4 with cnt=0 -> underflow=1 and stays 1 until rst; busy[4] stays 0.
